// File: rtl/rle_engine_p_if.sv
// DPSRAM port-A bus used by rle_engine_p: the engine is the master, the memory the slave.
interface rle_engine_p_if #(
    parameter int ADDR_W = 16
);
    logic              port_A_clk;
    logic [31:0]       port_A_data_in;
    logic [31:0]       port_A_data_out;
    logic [ADDR_W-1:0] port_A_addr;
    logic              port_A_we;

    modport master (
        output port_A_clk,
        output port_A_data_in,
        output port_A_addr,
        output port_A_we,
        input  port_A_data_out
    );

    modport slave (
        input  port_A_clk,
        input  port_A_data_in,
        input  port_A_addr,
        input  port_A_we,
        output port_A_data_out
    );
endinterface

// File: rtl/rle_engine_p.sv
// Run-length encoder: reads a message over DPSRAM port A and writes packed {count, symbol} records.
// Optional cycle counter output is enabled by defining RLE_CYCLE_CNT_EN.
module rle_engine_p #(
    parameter int SYM_BYTES = 1,
    parameter int CNT_BYTES = 1,
    parameter int ADDR_W    = 16
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic [31:0] message_addr,
    input  logic [31:0] message_size,
    input  logic [31:0] rle_addr,
    output logic [31:0] rle_size,
    output logic        done,
`ifdef RLE_CYCLE_CNT_EN
    output logic [31:0] cycles,
`endif
    rle_engine_p_if.master port_a
);
    localparam int SW  = 8 * SYM_BYTES;
    localparam int CW  = 8 * CNT_BYTES;
    localparam int RB  = SYM_BYTES + CNT_BYTES;
    localparam int RW  = 8 * RB;
    localparam int SPW = 4 / SYM_BYTES;
    localparam logic [3:0] RB4      = 4'(RB);
    localparam logic [1:0] LAST_IDX = 2'(SPW - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_SCAN, S_WR, S_FLUSH, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       rem_q, rem_d;
    logic [1:0]        sym_idx_q, sym_idx_d;
    logic              first_q, first_d;
    logic [31:0]       word_q, word_d;
    logic [SW-1:0]     run_sym_q, run_sym_d;
    logic [CW-1:0]     run_cnt_q, run_cnt_d;
    logic              run_vld_q, run_vld_d;
    logic [63:0]       pk_q, pk_d;
    logic [2:0]        pk_cnt_q, pk_cnt_d;
    logic [31:0]       acc_q, acc_d;
    logic [31:0]       rle_size_q, rle_size_d;
    logic              done_q, done_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       din_q, din_d;
`ifdef RLE_CYCLE_CNT_EN
    logic [31:0]       cyc_q, cyc_d;
`endif

    logic [31:0]   wd;
    logic [31:0]   sym_sh;
    logic [SW-1:0] cur_sym;
    logic [63:0]   rec_al;
    logic [3:0]    pk_sum;
    logic          append;
    logic          last_msg;
    logic          last_word;
    logic          unused_addr_bits;

    // The first SCAN cycle after a read takes the word straight off the memory bus.
    assign wd        = first_q ? port_a.port_A_data_out : word_q;
    assign sym_sh    = wd << (sym_idx_q * SW);
    assign cur_sym   = sym_sh[31 -: SW];
    assign rec_al    = {run_cnt_q, run_sym_q, {(64 - RW){1'b0}}} >> {pk_cnt_q, 3'b000};
    assign pk_sum    = {1'b0, pk_cnt_q} + RB4;
    assign last_msg  = (rem_q == 32'(SYM_BYTES));
    assign last_word = (sym_idx_q == LAST_IDX);
    assign unused_addr_bits = ^{message_addr[31:ADDR_W], rle_addr[31:ADDR_W]};

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        rem_d      = rem_q;
        sym_idx_d  = sym_idx_q;
        first_d    = first_q;
        word_d     = word_q;
        run_sym_d  = run_sym_q;
        run_cnt_d  = run_cnt_q;
        run_vld_d  = run_vld_q;
        pk_d       = pk_q;
        pk_cnt_d   = pk_cnt_q;
        acc_d      = acc_q;
        rle_size_d = rle_size_q;
        done_d     = done_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        din_d      = din_q;
        append     = 1'b0;
`ifdef RLE_CYCLE_CNT_EN
        cyc_d      = cyc_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    rd_addr_d  = message_addr[ADDR_W-1:0];
                    wr_addr_d  = rle_addr[ADDR_W-1:0];
                    rem_d      = message_size;
                    sym_idx_d  = 2'd0;
                    run_vld_d  = 1'b0;
                    pk_d       = 64'd0;
                    pk_cnt_d   = 3'd0;
                    acc_d      = 32'd0;
                    rle_size_d = 32'd0;
                    done_d     = (message_size == 32'd0);
                    state_d    = (message_size == 32'd0) ? S_DONE : S_RD_REQ;
`ifdef RLE_CYCLE_CNT_EN
                    cyc_d      = 32'd1;
`endif
                end
            end
            S_RD_REQ: begin
                addr_d    = rd_addr_q;
                rd_addr_d = rd_addr_q + ADDR_W'(4);
                state_d   = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                first_d   = 1'b1;
                sym_idx_d = 2'd0;
                state_d   = S_SCAN;
            end
            S_SCAN: begin
                first_d = 1'b0;
                if (first_q) word_d = port_a.port_A_data_out;
                if (!run_vld_q) begin
                    run_sym_d = cur_sym;
                    run_cnt_d = CW'(1);
                    run_vld_d = 1'b1;
                end else if (cur_sym == run_sym_q && run_cnt_q != {CW{1'b1}}) begin
                    run_cnt_d = run_cnt_q + CW'(1);
                end else begin
                    append    = 1'b1;
                    run_sym_d = cur_sym;
                    run_cnt_d = CW'(1);
                end
                rem_d     = rem_q - 32'(SYM_BYTES);
                sym_idx_d = last_word ? 2'd0 : sym_idx_q + 2'd1;
                if (append && pk_sum >= 4'd4) state_d = S_WR;
                else if (last_msg)            state_d = S_FLUSH;
                else if (last_word)           state_d = S_RD_REQ;
                else                          state_d = S_SCAN;
            end
            S_WR: begin
                // Bytes beyond pk_cnt are always zero, so a partial word goes out already padded.
                we_d      = 1'b1;
                addr_d    = wr_addr_q;
                din_d     = pk_q[63:32];
                wr_addr_d = wr_addr_q + ADDR_W'(4);
                pk_d      = pk_q << 32;
                pk_cnt_d  = (pk_cnt_q >= 3'd4) ? pk_cnt_q - 3'd4 : 3'd0;
                if (rem_q == 32'd0)         state_d = S_FLUSH;
                else if (sym_idx_q == 2'd0) state_d = S_RD_REQ;
                else                        state_d = S_SCAN;
            end
            S_FLUSH: begin
                if (run_vld_q) begin
                    append    = 1'b1;
                    run_vld_d = 1'b0;
                    state_d   = (pk_sum >= 4'd4) ? S_WR : S_FLUSH;
                end else if (pk_cnt_q != 3'd0) begin
                    state_d = S_WR;
                end else begin
                    rle_size_d = acc_q;
                    done_d     = 1'b1;
                    state_d    = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (append) begin
            pk_d     = pk_q | rec_al;
            pk_cnt_d = pk_sum[2:0];
            acc_d    = acc_q + 32'(RB);
        end
`ifdef RLE_CYCLE_CNT_EN
        if (state_q != S_IDLE && state_q != S_DONE) cyc_d = cyc_q + 32'd1;
`endif
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= S_IDLE;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            rem_q      <= '0;
            sym_idx_q  <= '0;
            first_q    <= 1'b0;
            word_q     <= '0;
            run_sym_q  <= '0;
            run_cnt_q  <= '0;
            run_vld_q  <= 1'b0;
            pk_q       <= '0;
            pk_cnt_q   <= '0;
            acc_q      <= '0;
            rle_size_q <= '0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
`ifdef RLE_CYCLE_CNT_EN
            cyc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            rem_q      <= rem_d;
            sym_idx_q  <= sym_idx_d;
            first_q    <= first_d;
            word_q     <= word_d;
            run_sym_q  <= run_sym_d;
            run_cnt_q  <= run_cnt_d;
            run_vld_q  <= run_vld_d;
            pk_q       <= pk_d;
            pk_cnt_q   <= pk_cnt_d;
            acc_q      <= acc_d;
            rle_size_q <= rle_size_d;
            done_q     <= done_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
`ifdef RLE_CYCLE_CNT_EN
            cyc_q      <= cyc_d;
`endif
        end
    end

    assign rle_size              = rle_size_q;
    assign done                  = done_q;
    assign port_a.port_A_clk     = clk;
    assign port_a.port_A_we      = we_q;
    assign port_a.port_A_addr    = addr_q;
    assign port_a.port_A_data_in = din_q;
`ifdef RLE_CYCLE_CNT_EN
    assign cycles                = cyc_q;
`endif
endmodule

// File: tb/tb_rle_engine_p.sv
// Directed bench for rle_engine_p: default and 16-bit-symbol instances, writes checked against a scoreboard.
module tb_rle_engine_p;
    logic        clk = 1'b0;
    logic        nreset;
    logic        start0, start1;
    logic [31:0] maddr, msize, raddr;
    logic [31:0] size0, size1;
    logic        done0, done1;
`ifdef RLE_CYCLE_CNT_EN
    logic [31:0] cyc0, cyc1;
`endif
    int          tid = 0;
    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp0[$];
    logic [63:0] exp1[$];
    logic [7:0]  mb[$];
    logic [31:0] last0 = 32'd0;

    always #5 clk = ~clk;

    rle_engine_p_if #(.ADDR_W(16)) if0 ();
    rle_engine_p_if #(.ADDR_W(16)) if1 ();

    rle_engine_p u0 (
        .clk(clk), .nreset(nreset), .start(start0),
        .message_addr(maddr), .message_size(msize), .rle_addr(raddr),
        .rle_size(size0), .done(done0),
`ifdef RLE_CYCLE_CNT_EN
        .cycles(cyc0),
`endif
        .port_a(if0)
    );

    rle_engine_p #(.SYM_BYTES(2), .CNT_BYTES(1), .ADDR_W(16)) u1 (
        .clk(clk), .nreset(nreset), .start(start1),
        .message_addr(maddr), .message_size(msize), .rle_addr(raddr),
        .rle_size(size1), .done(done1),
`ifdef RLE_CYCLE_CNT_EN
        .cycles(cyc1),
`endif
        .port_a(if1)
    );

    function automatic logic [7:0] msg_byte(input int t, input int i);
        logic [63:0] p4;
        p4 = 64'h1234_1234_5678_5678;
        if (i < 0) return 8'h5A;
        case (t)
            1: return (i < 39) ? 8'(8'hA0 + i) : 8'h5A;
            2: return (i < 300) ? 8'hAA : 8'h5A;
            4: return (i < 8) ? p4[63 - 8*i -: 8] : 8'h5A;
            default: return 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] word_at(input int t, input logic [31:0] base, input logic [15:0] a);
        int off;
        off = int'({16'h0, a}) - int'(base);
        return {msg_byte(t, off), msg_byte(t, off + 1), msg_byte(t, off + 2), msg_byte(t, off + 3)};
    endfunction

    // Memory models: read data registered on port_A_clk, one cycle after the address.
    always @(posedge if0.port_A_clk) if0.port_A_data_out <= word_at(tid, maddr, if0.port_A_addr);
    always @(posedge if1.port_A_clk) if1.port_A_data_out <= word_at(tid, maddr, if1.port_A_addr);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        logic [63:0] e;
        if (if0.port_A_we !== 1'b0) begin
            e = (exp0.size() > 0) ? exp0.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
            check("wr0", {16'h0, if0.port_A_addr, if0.port_A_data_in}, e);
            last0 = if0.port_A_data_in;
        end
        if (if1.port_A_we !== 1'b0) begin
            e = (exp1.size() > 0) ? exp1.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
            check("wr1", {16'h0, if1.port_A_addr, if1.port_A_data_in}, e);
        end
    end

    task automatic emit_rec(input logic [15:0] c, input logic [15:0] s, input int sb, input int cb);
        if (cb == 2) mb.push_back(c[15:8]);
        mb.push_back(c[7:0]);
        if (sb == 2) mb.push_back(s[15:8]);
        mb.push_back(s[7:0]);
    endtask

    // Reference encoder: builds the expected word stream for instance 0.
    task automatic model_push(input int sb, input int cb, input logic [31:0] rbase, input int size);
        logic [15:0] s, rs;
        logic [31:0] w;
        int rc, mx, nw;
        bit rv;
        mb.delete();
        rv = 1'b0; rs = 16'h0; rc = 0;
        mx = (1 << (8 * cb)) - 1;
        for (int i = 0; i < size; i += sb) begin
            s = (sb == 2) ? {msg_byte(tid, i), msg_byte(tid, i + 1)} : {8'h00, msg_byte(tid, i)};
            if (rv && s == rs && rc < mx) rc++;
            else begin
                if (rv) emit_rec(16'(rc), rs, sb, cb);
                rs = s; rc = 1; rv = 1'b1;
            end
        end
        if (rv) emit_rec(16'(rc), rs, sb, cb);
        while (mb.size() % 4 != 0) mb.push_back(8'h00);
        nw = mb.size() / 4;
        for (int k = 0; k < nw; k++) begin
            w = {mb[4*k], mb[4*k+1], mb[4*k+2], mb[4*k+3]};
            exp0.push_back({rbase + 32'(4 * k), w});
        end
    endtask

    task automatic pulse(input int which);
        @(negedge clk);
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int budget, input string tag);
        int n;
        n = 0;
        while (((which == 0) ? done0 : done1) !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'((which == 0) ? done0 : done1), 64'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_size"}, 64'(size0), 64'd0);
        check({tag, "_done"}, 64'(done0), 64'd0);
        check({tag, "_we"},   64'(if0.port_A_we), 64'd0);
        check({tag, "_addr"}, 64'(if0.port_A_addr), 64'd0);
        check({tag, "_din"},  64'(if0.port_A_data_in), 64'd0);
    endtask

    initial begin
        nreset = 1'b0; start0 = 1'b0; start1 = 1'b0;
        maddr = 32'h0; msize = 32'h0; raddr = 32'h0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        nreset = 1'b1;

        // 39 distinct-adjacent bytes -> 39 two-byte records at 0xC8
        tid = 1; maddr = 32'h200; msize = 32'd39; raddr = 32'hC8;
        model_push(1, 1, 32'hC8, 39);
        pulse(0);
        wait_done(0, 2000, "t1_done");
        check("t1_size", 64'(size0), 64'd78);
        check("t1_writes_left", 64'(exp0.size()), 64'd0);
        check("t1_last_word", 64'(last0), 64'h01C6_0000);

        // 300 bytes of 0xAA, with a stray start issued while busy
        tid = 2; maddr = 32'h0; msize = 32'd300; raddr = 32'h800;
        exp0.push_back({32'h800, 32'hFFAA_2DAA});
        pulse(0);
        repeat (20) @(negedge clk);
        msize = 32'd4; raddr = 32'h900;
        pulse(0);
        wait_done(0, 2000, "t2_done");
        check("t2_size", 64'(size0), 64'd4);
        check("t2_writes_left", 64'(exp0.size()), 64'd0);

        // empty message
        tid = 0; msize = 32'd0; raddr = 32'hA00;
        pulse(0);
        wait_done(0, 2, "t3_done_fast");
        check("t3_size", 64'(size0), 64'd0);

        // 16-bit symbols, 8-bit counts
        tid = 4; maddr = 32'h40; msize = 32'd8; raddr = 32'h100;
        exp1.push_back({32'h100, 32'h0212_3402});
        exp1.push_back({32'h104, 32'h5678_0000});
        pulse(1);
        wait_done(1, 200, "t4_done");
        check("t4_size", 64'(size1), 64'd6);
        check("t4_writes_left", 64'(exp1.size()), 64'd0);

        // abort mid-job with reset, then rerun the first job
        tid = 1; maddr = 32'h200; msize = 32'd39; raddr = 32'hC8;
        model_push(1, 1, 32'hC8, 39);
        pulse(0);
        repeat (10) @(negedge clk);
        #2 nreset = 1'b0;
        exp0.delete();
        #1 check_reset_vals("abort");
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_idle_done", 64'(done0), 64'd0);
        model_push(1, 1, 32'hC8, 39);
        pulse(0);
        wait_done(0, 2000, "t5_done");
        check("t5_size", 64'(size0), 64'd78);
        check("t5_writes_left", 64'(exp0.size()), 64'd0);
        check("t5_last_word", 64'(last0), 64'h01C6_0000);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
